// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the programmable clock divider.
package clk_div_pkg;

    // Controller states; PEND means running with a ratio change queued.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    // Smallest ratio that still yields a high and a low phase.
    localparam int MIN_DIV = 2;

    // Width of the optional completed-period counter.
    localparam int PCNT_W = 16;

endpackage : clk_div_pkg

// File: rtl/div_counter.sv
// div_counter: period counter for the clock divider. Counts 0..N-1, flags the
// wrap cycle, and produces the registered divided clock level and tick.
module div_counter #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             active,
    input  logic             halt,
    input  logic [DIV_W-1:0] n_cur,
    output logic             wrap,
    output logic             clk_out,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] half;
    logic             clk_out_q;
    logic             clk_out_d;
    logic             tick_q;
    logic             tick_d;

    assign half    = n_cur >> 1;
    assign cnt_inc = cnt_q + DIV_W'(1);
    assign wrap    = active && (cnt_q == (n_cur - DIV_W'(1)));

    // Next count and output levels; a new period always opens high with a tick
    // because any legal ratio has at least one high cycle.
    always_comb begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        if (start) begin
            cnt_d     = '0;
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
        end else if (active) begin
            if (wrap) begin
                cnt_d     = '0;
                clk_out_d = !halt;
                tick_d    = !halt;
            end else begin
                cnt_d     = cnt_inc;
                clk_out_d = (cnt_inc < half);
                tick_d    = 1'b0;
            end
        end
    end

    // Counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule : div_counter

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock-divider controller with run/stop control and
// a req/ack ratio-change handshake applied only on period boundaries.
// Optional feature: define CLK_DIV_CNT_EN to add the period_cnt output.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | stopped, clk_out low; ratio requests applied immediately
// RUN     | dividing with cur_div
// PEND    | dividing with cur_div, new ratio held until the next wrap
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] cur_div,
    output logic             busy
`ifdef CLK_DIV_CNT_EN
    ,
    output logic [PCNT_W-1:0] period_cnt
`endif
);

    localparam logic [DIV_W-1:0] MIN_DIV_W = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] DEF_DIV_W = DIV_W'(DEF_DIV);

    state_t           state_q;
    state_t           state_d;
    logic [DIV_W-1:0] cur_div_q;
    logic [DIV_W-1:0] cur_div_d;
    logic [DIV_W-1:0] pend_q;
    logic [DIV_W-1:0] pend_d;
    logic             ack_pipe_q;
    logic             ack_pipe_d;
    logic             err_pipe_q;
    logic             err_pipe_d;
    logic             ack_q;
    logic             ack_d;
    logic             err_q;
    logic             err_d;

    logic             active;
    logic             start;
    logic             wrap;
    logic             stop_now;
    logic             req_valid;
    logic             accept;

    assign active    = (state_q != ST_IDLE);
    assign stop_now  = wrap && !en;
    assign req_valid = (div_val >= MIN_DIV_W);

    // A request is taken only when no ack is in flight and nothing is queued.
    // The stopping wrap edge is skipped so the request lands cleanly in IDLE.
    assign accept = div_req && !ack_q && !ack_pipe_q &&
                    ((state_q == ST_IDLE) || ((state_q == ST_RUN) && !stop_now));

    div_counter #(
        .DIV_W (DIV_W)
    ) u_div_counter (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .active  (active),
        .halt    (!en),
        .n_cur   (cur_div_q),
        .wrap    (wrap),
        .clk_out (clk_out),
        .tick    (tick)
    );

    // Next-state, ratio and handshake logic; the ack is issued one cycle after
    // the edge on which the request is completed.
    always_comb begin
        state_d    = state_q;
        cur_div_d  = cur_div_q;
        pend_d     = pend_q;
        ack_pipe_d = 1'b0;
        err_pipe_d = 1'b0;
        ack_d      = ack_pipe_q;
        err_d      = err_pipe_q;
        start      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ack_pipe_d = 1'b1;
                    err_pipe_d = !req_valid;
                    if (req_valid) begin
                        cur_div_d = div_val;
                    end
                end
                if (en) begin
                    start   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_now) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    if (req_valid) begin
                        pend_d  = div_val;
                        state_d = ST_PEND;
                    end else begin
                        ack_pipe_d = 1'b1;
                        err_pipe_d = 1'b1;
                    end
                end
            end
            ST_PEND: begin
                if (wrap) begin
                    cur_div_d  = pend_q;
                    pend_d     = '0;
                    ack_pipe_d = 1'b1;
                    state_d    = en ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_div_q  <= DEF_DIV_W;
            pend_q     <= '0;
            ack_pipe_q <= 1'b0;
            err_pipe_q <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            pend_q     <= pend_d;
            ack_pipe_q <= ack_pipe_d;
            err_pipe_q <= err_pipe_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign div_ack = ack_q;
    assign div_err = err_q;
    assign cur_div = cur_div_q;
    assign busy    = active;

`ifdef CLK_DIV_CNT_EN
    logic [PCNT_W-1:0] pcnt_q;
    logic [PCNT_W-1:0] pcnt_d;

    // Completed periods, saturating; restarted by each accepted valid change.
    always_comb begin
        pcnt_d = pcnt_q;
        if (accept && req_valid) begin
            pcnt_d = '0;
        end else if (wrap && (pcnt_q != {PCNT_W{1'b1}})) begin
            pcnt_d = pcnt_q + PCNT_W'(1);
        end
    end

    // Period counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign period_cnt = pcnt_q;
`endif

endmodule : clk_div_ctrl
